// File: rtl/majority_window_voter_pkg.sv
// Shared sizing and counting helpers for the majority voter family.
// Latency: n/a (constant functions and parameters only).
// Backpressure: n/a.
package majority_pkg;

    localparam int MAX_N      = 64;
    localparam int SW_DEFAULT = 16;

    // Width able to hold the values 0..n; never below one bit.
    function automatic int cw_of(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    function automatic int unsigned popcount(input logic [MAX_N-1:0] v);
        int unsigned c;
        c = 0;
        for (int i = 0; i < MAX_N; i++) begin
            c += 32'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/majority_window_voter_if.sv
// Sample-in / result-out stream bundle for the majority voter.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on both the sample and the result side.
interface majority_window_voter_if
    import majority_pkg::*;
#(
    parameter int N = 5
);
    localparam int CW = cw_of(N);

    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  data;
    logic [CW-1:0] thr;

    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] count;
    logic          y_raw;
    logic          y_filt;
    logic          disagree;

    modport slave (
        input  in_valid, data, thr, out_ready,
        output in_ready, out_valid, count, y_raw, y_filt, disagree
    );

    modport master (
        output in_valid, data, thr, out_ready,
        input  in_ready, out_valid, count, y_raw, y_filt, disagree
    );

endinterface

// File: rtl/majority_window_voter_popcount.sv
// Combinational N-bit population count, result CW bits wide.
// Latency: 0 cycles.
// Backpressure: none (pure combinational).
module popcount_n
    import majority_pkg::*;
#(
    parameter  int N  = 5,
    localparam int CW = cw_of(N)
) (
    input  logic [N-1:0]  bits,
    output logic [CW-1:0] count
);

    logic [MAX_N-1:0] ext;

    always_comb begin
        ext   = MAX_N'(bits);
        count = CW'(popcount(ext));
    end

endmodule

// File: rtl/majority_window_voter.sv
// N-input threshold voter with a DEPTH-deep temporal majority filter and a disagreement counter.
// Latency: 2 cycles (S1 holds the sample, S2 holds the voted result).
// Backpressure: full skid-free valid/ready; a stalled output holds both stages, in_ready drops when both are full.
module majority_window_voter
    import majority_pkg::*;
#(
    parameter int N     = 5,
    parameter int DEPTH = 3,
    parameter int SW    = SW_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    majority_window_voter_if.slave   bus,
    input  logic                     clr_stats,
    output logic [SW-1:0]            stat_cnt
);

    localparam int CW   = cw_of(N);
    localparam int SUMW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [N-1:0]  data;
        logic [CW-1:0] thr;
    } s1_t;

    typedef struct packed {
        logic [CW-1:0] count;
        logic          y_raw;
        logic          y_filt;
        logic          disagree;
    } res_t;

    logic          s1_valid;
    s1_t           s1_q;
    logic          out_valid_q;
    res_t          s2_q;
    res_t          res_new;

    logic          adv2;
    logic          load2;
    logic          in_ready;
    logic          in_fire;
    logic          out_fire;

    logic [CW-1:0] cnt_new;
    logic          y_raw_new;
    logic          y_filt_new;
    logic          disagree_new;

    assign adv2     = !out_valid_q || bus.out_ready;
    assign load2    = s1_valid && adv2;
    assign in_ready = !s1_valid || adv2;
    assign in_fire  = bus.in_valid && in_ready;
    assign out_fire = out_valid_q && bus.out_ready;

    popcount_n #(.N(N)) u_popcount (
        .bits  (s1_q.data),
        .count (cnt_new)
    );

    // thr travels with its sample, so a threshold change never touches in-flight results.
    assign y_raw_new    = (cnt_new >= s1_q.thr);
    assign disagree_new = (cnt_new != '0) && (cnt_new != CW'(N));

    generate
        if (DEPTH <= 1) begin : g_nofilt
            assign y_filt_new = y_raw_new;
        end else begin : g_filt
            localparam int HW = DEPTH - 1;

            logic [HW-1:0]   hist_q;
            logic [SUMW-1:0] hsum_q;
            logic [SUMW-1:0] tot;

            assign tot        = hsum_q + SUMW'(y_raw_new);
            assign y_filt_new = (tot > SUMW'(DEPTH / 2));

            // Window slides only when a result actually lands in S2.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    hist_q <= '0;
                    hsum_q <= '0;
                end else if (load2) begin
                    hist_q <= (hist_q << 1) | HW'(y_raw_new);
                    hsum_q <= tot - SUMW'(hist_q[HW-1]);
                end
            end
        end
    endgenerate

    always_comb begin
        res_new          = '0;
        res_new.count    = cnt_new;
        res_new.y_raw    = y_raw_new;
        res_new.y_filt   = y_filt_new;
        res_new.disagree = disagree_new;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else if (in_fire) begin
            s1_valid <= 1'b1;
            s1_q     <= '{data: bus.data, thr: bus.thr};
        end else if (load2) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            s2_q        <= '0;
        end else if (adv2) begin
            out_valid_q <= s1_valid;
            if (s1_valid) begin
                s2_q <= res_new;
            end
        end
    end

    // Clear wins over a same-cycle increment; the count sticks at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_cnt <= '0;
        end else if (clr_stats) begin
            stat_cnt <= '0;
        end else if (out_fire && s2_q.disagree && (stat_cnt != '1)) begin
            stat_cnt <= stat_cnt + 1'b1;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.count     = s2_q.count;
    assign bus.y_raw     = s2_q.y_raw;
    assign bus.y_filt    = s2_q.y_filt;
    assign bus.disagree  = s2_q.disagree;

endmodule

// File: tb/tb_majority_window_voter.sv
// Directed bench for majority_window_voter: N=5, DEPTH=3, SW=2 so saturation is reachable.
// Expected values are hand-computed per vector.
module tb_majority_window_voter;
    import majority_pkg::*;

    localparam int N     = 5;
    localparam int DEPTH = 3;
    localparam int SW    = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clr_stats = 1'b0;
    logic [SW-1:0] stat_cnt;

    majority_window_voter_if #(.N(N)) bus ();

    majority_window_voter #(.N(N), .DEPTH(DEPTH), .SW(SW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .clr_stats (clr_stats),
        .stat_cnt  (stat_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] count;
        logic       y_raw;
        logic       y_filt;
        logic       disagree;
    } rec_t;

    rec_t outq[$];
    int   outcyc[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every result transfer; sampled mid-cycle, the transfer happens at the next rising edge.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            outq.push_back({bus.count, bus.y_raw, bus.y_filt, bus.disagree});
            outcyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic timed_out(input string tag);
        n_chk++;
        n_err++;
        $display("FAIL %s: no progress within cycle budget", tag);
    endtask

    task automatic push(input logic [4:0] d, input logic [2:0] t);
        logic acc;
        int   budget;
        budget       = 50;
        bus.in_valid = 1'b1;
        bus.data     = d;
        bus.thr      = t;
        do begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            budget--;
        end while (!acc && budget > 0);
        if (!acc) timed_out("push");
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_outs(input int n);
        int budget;
        budget = 100;
        while (outq.size() < n && budget > 0) begin
            @(posedge clk);
            #1;
            budget--;
        end
        if (outq.size() < n) timed_out("drain");
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    logic [4:0] t2_dat [3] = '{5'b00000, 5'b11111, 5'b11000};
    int         t2_cnt [3] = '{0, 5, 2};
    int         t2_raw [3] = '{0, 1, 0};
    int         t2_dis [3] = '{0, 0, 1};
    logic [4:0] t3_dat [4] = '{5'b00111, 5'b10000, 5'b11110, 5'b01010};
    int         t3_cnt [4] = '{3, 1, 4, 2};
    int         t3_raw [4] = '{1, 0, 1, 0};
    int         t4_raw [6] = '{1, 0, 1, 1, 0, 0};
    int         t4_flt [6] = '{0, 0, 1, 1, 1, 0};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nrec;
        int b;
        bus.in_valid  = 1'b0;
        bus.data      = '0;
        bus.thr       = '0;
        bus.out_ready = 1'b1;
        do_reset();

        // Reset state
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_count",     bus.count,     0);
        check("rst_y_raw",     bus.y_raw,     0);
        check("rst_y_filt",    bus.y_filt,    0);
        check("rst_disagree",  bus.disagree,  0);
        check("rst_stat",      stat_cnt,      0);
        check("rst_in_ready",  bus.in_ready,  1);

        // Single sample, two-cycle latency
        outq.delete();
        bus.in_valid = 1'b1;
        bus.data     = 5'b10110;
        bus.thr      = 3'd3;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        check("t1_valid_early", bus.out_valid, 0);
        @(posedge clk);
        #1;
        check("t1_valid",    bus.out_valid, 1);
        check("t1_count",    bus.count,     3);
        check("t1_y_raw",    bus.y_raw,     1);
        check("t1_disagree", bus.disagree,  1);
        check("t1_y_filt",   bus.y_filt,    0);
        @(posedge clk);
        #1;
        check("t1_stat",        stat_cnt,      1);
        check("t1_valid_after", bus.out_valid, 0);

        clr_stats = 1'b1;
        @(posedge clk);
        #1 clr_stats = 1'b0;
        check("clr_stat", stat_cnt, 0);

        // Back-to-back, no stall
        outq.delete();
        outcyc.delete();
        for (int i = 0; i < 3; i++) push(t2_dat[i], 3'd3);
        wait_outs(3);
        if (outq.size() >= 3) begin
            for (int i = 0; i < 3; i++) begin
                check($sformatf("t2_count%0d", i), outq[i].count,    t2_cnt[i]);
                check($sformatf("t2_raw%0d", i),   outq[i].y_raw,    t2_raw[i]);
                check($sformatf("t2_dis%0d", i),   outq[i].disagree, t2_dis[i]);
                if (i > 0) check($sformatf("t2_gap%0d", i), outcyc[i] - outcyc[i-1], 1);
            end
        end
        check("t2_stat", stat_cnt, 1);

        // Output stall with input held
        outq.delete();
        bus.out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++) push(t3_dat[i], 3'd3);
            end
            begin
                for (int i = 1; i <= 4; i++) begin
                    @(negedge clk);
                    if (i >= 3) begin
                        check($sformatf("t3_in_ready%0d", i), bus.in_ready,  0);
                        check($sformatf("t3_valid%0d", i),    bus.out_valid, 1);
                        check($sformatf("t3_hold_cnt%0d", i), bus.count,     3);
                        check($sformatf("t3_hold_raw%0d", i), bus.y_raw,     1);
                        check($sformatf("t3_no_xfer%0d", i),  outq.size(),   0);
                    end
                    @(posedge clk);
                    #1;
                end
                bus.out_ready = 1'b1;
            end
        join
        wait_outs(4);
        repeat (3) @(posedge clk);
        #1;
        check("t3_total", outq.size(), 4);
        if (outq.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                check($sformatf("t3_count%0d", i), outq[i].count, t3_cnt[i]);
                check($sformatf("t3_raw%0d", i),   outq[i].y_raw, t3_raw[i]);
            end
        end

        // Temporal filter from a zero-filled history
        do_reset();
        outq.delete();
        for (int i = 0; i < 6; i++) push((t4_raw[i] != 0) ? 5'b11111 : 5'b00000, 3'd3);
        wait_outs(6);
        if (outq.size() >= 6) begin
            for (int i = 0; i < 6; i++) begin
                check($sformatf("t4_raw%0d", i),  outq[i].y_raw,  t4_raw[i]);
                check($sformatf("t4_filt%0d", i), outq[i].y_filt, t4_flt[i]);
            end
        end

        // Threshold extremes and clear priority
        outq.delete();
        push(5'b00000, 3'd0);
        push(5'b11111, 3'd6);
        wait_outs(2);
        if (outq.size() >= 2) begin
            check("t5_thr0_raw", outq[0].y_raw, 1);
            check("t5_thr6_cnt", outq[1].count, 5);
            check("t5_thr6_raw", outq[1].y_raw, 0);
        end
        push(5'b01100, 3'd3);
        wait_outs(3);
        check("t5_stat_pre", stat_cnt, 1);

        bus.out_ready = 1'b0;
        push(5'b00011, 3'd2);
        b = 20;
        while (!bus.out_valid && b > 0) begin
            @(posedge clk);
            #1;
            b--;
        end
        if (!bus.out_valid) timed_out("t5_wait_valid");
        bus.out_ready = 1'b1;
        clr_stats     = 1'b1;
        @(posedge clk);
        #1 clr_stats = 1'b0;
        check("t5_clr_prio", stat_cnt, 0);
        check("t5_xfer", outq.size(), 4);
        if (outq.size() >= 4) check("t5_dis", outq[3].disagree, 1);

        // Saturation at 2^SW-1
        outq.delete();
        for (int i = 0; i < 5; i++) push(5'b10101, 3'd3);
        wait_outs(5);
        check("t6_sat", stat_cnt, 3);

        // Reset in the middle of a busy stream
        bus.in_valid = 1'b1;
        bus.data     = 5'b11000;
        bus.thr      = 3'd3;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("t6_busy_valid", bus.out_valid, 1);
        #2 rst_n = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        nrec = outq.size();
        check("t6_rst_valid", bus.out_valid, 0);
        check("t6_rst_count", bus.count,     0);
        check("t6_rst_stat",  stat_cnt,      0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("t6_post_valid", bus.out_valid, 0);
        check("t6_no_stale",   outq.size(),   nrec);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
